// File: rtl/seg7_scan_if.sv
// Scanned seven-segment bus plus decoded results, shared by the bus driver and the decoder.
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic [6:0]              seg_n;
   logic [NUM_DIGITS-1:0]   dig_sel_n;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [NUM_DIGITS-1:0]   digit_valid;
   logic                    frame_done;
   logic                    err;
   logic [2:0]              err_digit;

   modport master (
      output seg_n, dig_sel_n,
      input  digits, digit_valid, frame_done, err, err_digit
   );

   modport slave (
      input  seg_n, dig_sel_n,
      output digits, digit_valid, frame_done, err, err_digit
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digit values from a multiplexed active-low seven-segment bus,
// committing a pattern only after it has been stable for STABLE_CYCLES samples.
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   seg7_scan_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

   typedef struct packed {
      logic       legal;
      logic       blank;
      logic [3:0] value;
   } glyph_t;

   localparam logic [3:0]            RUN_MAX  = 4'(STABLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN = {NUM_DIGITS{1'b1}};

   state_t                  state;
   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   sel_q;
   logic [3:0]              run_cnt;
   logic [NUM_DIGITS-1:0]   seen;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   valid_q;
   logic                    frame_q;
   logic                    err_q;
   logic [2:0]              err_digit_q;

   logic                    sel_ok;
   logic                    same;
   logic [NUM_DIGITS-1:0]   commit_mask;
   logic [NUM_DIGITS-1:0]   seen_next;
   logic [2:0]              commit_idx;
   glyph_t                  glyph;

   function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] sel);
      int n;
      n = 0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!sel[i]) n++;
      return n == 1;
   endfunction

   function automatic logic [2:0] low_index(input logic [NUM_DIGITS-1:0] sel);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!sel[i]) idx = 3'(i);
      return idx;
   endfunction

   function automatic glyph_t decode(input logic [6:0] seg);
      glyph_t g;
      g = '{legal: 1'b1, blank: 1'b0, value: 4'h0};
      case (seg)
         7'b1000000: g.value = 4'h0;
         7'b1111001: g.value = 4'h1;
         7'b0100100: g.value = 4'h2;
         7'b0110000: g.value = 4'h3;
         7'b0011001: g.value = 4'h4;
         7'b0010010: g.value = 4'h5;
         7'b0000010: g.value = 4'h6;
         7'b1111000: g.value = 4'h7;
         7'b0000000: g.value = 4'h8;
         7'b0011000: g.value = 4'h9;
         7'b0001000: g.value = 4'hA;
         7'b0000011: g.value = 4'hB;
         7'b1000110: g.value = 4'hC;
         7'b0100001: g.value = 4'hD;
         7'b0000110: g.value = 4'hE;
         7'b0001110: g.value = 4'hF;
         7'b1111111: begin
            g.legal = 1'b0;
            g.blank = 1'b1;
         end
         default:    g.legal = 1'b0;
      endcase
      return g;
   endfunction

   // The held sample (not the live pins) is what gets committed.
   assign sel_ok      = one_hot_low(bus.dig_sel_n);
   assign same        = (bus.seg_n == seg_q) && (bus.dig_sel_n == sel_q);
   assign commit_mask = ~sel_q;
   assign commit_idx  = low_index(sel_q);
   assign glyph       = decode(seg_q);
   assign seen_next   = seen | commit_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the digit store is reset too, so a freshly reset decoder reads all zeros rather than X.
         state       <= IDLE;
         seg_q       <= 7'h7F;
         sel_q       <= '1;
         run_cnt     <= 4'd0;
         seen        <= '0;
         digits_q    <= '0;
         valid_q     <= '0;
         frame_q     <= 1'b0;
         err_q       <= 1'b0;
         err_digit_q <= 3'd0;
      end else begin
         frame_q <= 1'b0;
         err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (sel_ok) begin
                  seg_q   <= bus.seg_n;
                  sel_q   <= bus.dig_sel_n;
                  run_cnt <= 4'd1;
                  state   <= COUNT;
               end else begin
                  run_cnt <= 4'd0;
               end
            end
            COUNT: begin
               if (run_cnt == RUN_MAX) begin
                  if (glyph.legal) begin
                     for (int i = 0; i < NUM_DIGITS; i++)
                        if (commit_mask[i]) digits_q[4*i +: 4] <= glyph.value;
                     valid_q <= valid_q | commit_mask;
                  end else if (glyph.blank) begin
                     valid_q <= valid_q & ~commit_mask;
                  end else begin
                     err_q       <= 1'b1;
                     err_digit_q <= commit_idx;
                  end
                  if (seen_next == ALL_SEEN) begin
                     frame_q <= 1'b1;
                     seen    <= '0;
                  end else begin
                     seen <= seen_next;
                  end
               end
               if (same) begin
                  if (run_cnt == RUN_MAX) state <= HOLD;
                  else run_cnt <= run_cnt + 4'd1;
               end else if (sel_ok) begin
                  seg_q   <= bus.seg_n;
                  sel_q   <= bus.dig_sel_n;
                  run_cnt <= 4'd1;
                  state   <= COUNT;
               end else begin
                  run_cnt <= 4'd0;
                  state   <= IDLE;
               end
            end
            HOLD: begin
               if (!same) begin
                  if (sel_ok) begin
                     seg_q   <= bus.seg_n;
                     sel_q   <= bus.dig_sel_n;
                     run_cnt <= 4'd1;
                     state   <= COUNT;
                  end else begin
                     run_cnt <= 4'd0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               run_cnt <= 4'd0;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.digits      = digits_q;
   assign bus.digit_valid = valid_q;
   assign bus.frame_done  = frame_q;
   assign bus.err         = err_q;
   assign bus.err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected commits are queued when a
// stable pattern is driven and popped whenever the decoder outputs move.
module tb_seg7_scan_decoder;

   localparam int ND = 4;
   localparam int SC = 4;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  valid;
      logic        err;
      logic [2:0]  err_digit;
      logic        frame;
   } exp_t;

   logic clk;
   logic rst_n;

   seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   int   frame_cnt   = 0;
   exp_t sb[$];

   logic [15:0] m_digits;
   logic [3:0]  m_valid;
   logic [2:0]  m_err_digit;
   logic [3:0]  m_seen;
   logic [15:0] prev_digits;
   logic [3:0]  prev_valid;

   logic [6:0] glyphs [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int low_count(input logic [3:0] sel);
      int n = 0;
      for (int i = 0; i < ND; i++) if (!sel[i]) n++;
      return n;
   endfunction

   task automatic model_reset();
      m_digits    = '0;
      m_valid     = '0;
      m_err_digit = '0;
      m_seen      = '0;
   endtask

   task automatic push_commit(input logic [6:0] seg, input logic [3:0] sel);
      exp_t e;
      int   idx;
      int   found;
      idx   = 0;
      found = -1;
      for (int i = 0; i < ND; i++) if (!sel[i]) idx = i;
      for (int g = 0; g < 16; g++) if (glyphs[g] == seg) found = g;
      e.err = 1'b0;
      if (found >= 0) begin
         m_digits[4*idx +: 4] = 4'(found);
         m_valid[idx]         = 1'b1;
      end else if (seg == 7'h7F) begin
         m_valid[idx] = 1'b0;
      end else begin
         e.err       = 1'b1;
         m_err_digit = 3'(idx);
      end
      m_seen[idx] = 1'b1;
      e.frame     = (m_seen == 4'hF);
      if (e.frame) m_seen = '0;
      e.digits    = m_digits;
      e.valid     = m_valid;
      e.err_digit = m_err_digit;
      sb.push_back(e);
   endtask

   // Drive a pattern for n rising edges; a long-enough one-hot run must commit.
   task automatic drive(input logic [6:0] seg, input logic [3:0] sel, input int n);
      bus.seg_n     = seg;
      bus.dig_sel_n = sel;
      if (n >= SC && low_count(sel) == 1) push_commit(seg, sel);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_check(input string name);
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("FAIL %s pending: got %0d expected commits not seen, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_digits = bus.digits;
         prev_valid  = bus.digit_valid;
      end else if (bus.err || bus.frame_done || bus.digits !== prev_digits || bus.digit_valid !== prev_valid) begin
         if (bus.frame_done === 1'b1) frame_cnt++;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_output: got digits=%h valid=%b err=%b frame=%b, expected no change",
                     bus.digits, bus.digit_valid, bus.err, bus.frame_done);
         end else begin
            e = sb.pop_front();
            vectors += 5;
            if (bus.digits !== e.digits) begin
               miscompares++;
               $display("FAIL commit_digits: got %h expected %h", bus.digits, e.digits);
            end
            if (bus.digit_valid !== e.valid) begin
               miscompares++;
               $display("FAIL commit_valid: got %b expected %b", bus.digit_valid, e.valid);
            end
            if (bus.err !== e.err) begin
               miscompares++;
               $display("FAIL commit_err: got %b expected %b", bus.err, e.err);
            end
            if (bus.err_digit !== e.err_digit) begin
               miscompares++;
               $display("FAIL commit_err_digit: got %0d expected %0d", bus.err_digit, e.err_digit);
            end
            if (bus.frame_done !== e.frame) begin
               miscompares++;
               $display("FAIL commit_frame: got %b expected %b", bus.frame_done, e.frame);
            end
         end
         prev_digits = bus.digits;
         prev_valid  = bus.digit_valid;
      end
   end

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.seg_n     = 7'h7F;
      bus.dig_sel_n = 4'hF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.digits, bus.digit_valid, bus.frame_done, bus.err, bus.err_digit} !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got digits=%h valid=%b frame=%b err=%b err_digit=%0d, expected all 0",
                  bus.digits, bus.digit_valid, bus.frame_done, bus.err, bus.err_digit);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency();
      bus.seg_n     = 7'b0110000;
      bus.dig_sel_n = 4'b1110;
      push_commit(7'b0110000, 4'b1110);
      repeat (SC) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.digit_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL latency_early: got valid=%b before edge 5, expected 0000", bus.digit_valid);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.digits[3:0] !== 4'h3 || bus.digit_valid !== 4'b0001 || bus.err !== 1'b0 || bus.frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_commit: got d0=%h valid=%b err=%b frame=%b, expected 3 0001 0 0",
                  bus.digits[3:0], bus.digit_valid, bus.err, bus.frame_done);
      end
      @(posedge clk);
      #1;
      drive(7'h7F, 4'hF, 2);
      drain_check("latency");
   endtask

   task automatic test_short_run();
      drive(7'b0110000, 4'b1110, SC - 1);
      drive(7'h7F, 4'hF, 3);
      drive(7'b1111000, 4'b1110, SC - 1);
      drive(7'h7F, 4'hF, 3);
      vectors++;
      if (bus.digits[3:0] !== 4'h3 || bus.digit_valid !== 4'b0001) begin
         miscompares++;
         $display("FAIL short_run: got d0=%h valid=%b, expected 3 0001", bus.digits[3:0], bus.digit_valid);
      end
      drain_check("short_run");
   endtask

   task automatic test_scan_frame();
      int f0;
      f0 = frame_cnt;
      drive(7'b1111001, 4'b1110, 6);
      drive(7'b0001000, 4'b1101, 6);
      drive(7'b0100100, 4'b1011, 6);
      drive(7'b0001110, 4'b0111, 6);
      drive(7'h7F, 4'hF, 2);
      drain_check("scan_frame");
      vectors++;
      if (bus.digits !== 16'hF2A1 || bus.digit_valid !== 4'b1111) begin
         miscompares++;
         $display("FAIL scan_result: got digits=%h valid=%b, expected F2A1 1111", bus.digits, bus.digit_valid);
      end
      vectors++;
      if (frame_cnt - f0 !== 1) begin
         miscompares++;
         $display("FAIL frame_count: got %0d pulses, expected 1", frame_cnt - f0);
      end
   endtask

   task automatic test_error_blank();
      drive(7'b0101010, 4'b1011, SC);
      drive(7'h7F, 4'hF, 3);
      vectors++;
      if (bus.err_digit !== 3'd2 || bus.digits[11:8] !== 4'h2 || bus.digit_valid[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL error_hold: got err_digit=%0d d2=%h v2=%b, expected 2 2 1",
                  bus.err_digit, bus.digits[11:8], bus.digit_valid[2]);
      end
      drive(7'h7F, 4'b1011, 6);
      drive(7'h7F, 4'hF, 2);
      drain_check("error_blank");
      vectors++;
      if (bus.digit_valid !== 4'b1011 || bus.digits !== 16'hF2A1 || bus.err_digit !== 3'd2) begin
         miscompares++;
         $display("FAIL blank_result: got valid=%b digits=%h err_digit=%0d, expected 1011 F2A1 2",
                  bus.digit_valid, bus.digits, bus.err_digit);
      end
   endtask

   task automatic test_bad_select_and_reset();
      drive(7'b0000000, 4'b0011, 20);
      drive(7'h7F, 4'hF, 2);
      drain_check("multi_select");
      bus.seg_n     = 7'b0010010;
      bus.dig_sel_n = 4'b1101;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      vectors++;
      if ({bus.digits, bus.digit_valid, bus.frame_done, bus.err, bus.err_digit} !== 25'd0) begin
         miscompares++;
         $display("FAIL midrun_reset: got digits=%h valid=%b err_digit=%0d, expected all 0",
                  bus.digits, bus.digit_valid, bus.err_digit);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_commit(7'b0010010, 4'b1101);
      repeat (SC) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.digit_valid !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_restart_early: got valid=%b, expected 0000", bus.digit_valid);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.digits !== 16'h0050 || bus.digit_valid !== 4'b0010) begin
         miscompares++;
         $display("FAIL reset_restart_commit: got digits=%h valid=%b, expected 0050 0010",
                  bus.digits, bus.digit_valid);
      end
      @(posedge clk);
      #1;
      drive(7'h7F, 4'hF, 2);
      drain_check("reset_restart");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_short_run();
      test_scan_frame();
      test_error_blank();
      test_bad_select_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Recovers hexadecimal digit values from a multiplexed, active-low seven-segment display bus (segment lines plus per-digit select), the inverse of the team's hex-to-7-segment encoding. It sits on the acceptance/test side of the display path: it samples the scanned bus, requires each pattern to be stable before accepting it, decodes it to a 4-bit value, and flags patterns that are not legal glyphs. Used for loopback self-checking of display drivers and for capturing display output into the verification fabric.

## Interface

- NUM_DIGITS, 4: number of multiplexed digits; legal 1..8.
- STABLE_CYCLES, 4: consecutive sampled cycles a pattern must hold before commit; legal 2..15.

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- seg_n  input  7  segment lines, active-low, bit 0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle.
- dig_sel_n  input  NUM_DIGITS  digit selects, active-low, exactly one low when valid.
- digits  output  4*NUM_DIGITS  decoded values; digit i in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  bit i = 1 when digit i last committed a legal non-blank glyph.
- frame_done  output  1  one-cycle pulse when every digit has committed since the previous pulse or reset.
- err  output  1  one-cycle pulse on commit of an illegal pattern.
- err_digit  output  3  index of digit that caused the latest err; holds until next err.

## Operation

- Legal glyphs (seg_n[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Blank = 1111111.
- Registered sample pair {seg_q, sel_q}; run counter run_cnt (4 bits, saturates at STABLE_CYCLES).
- FSM states:
  - IDLE: dig_sel_n not exactly one-hot-low. run_cnt <= 0. Goes to COUNT when a one-hot-low select appears (run_cnt <= 1).
  - COUNT: each edge, pins equal {seg_q, sel_q} -> run_cnt +1; pins differ but select valid -> run_cnt <= 1, stay; select invalid -> IDLE. When run_cnt == STABLE_CYCLES: commit, go to HOLD.
  - HOLD: pattern already committed; no further commit while pins unchanged. Pin change with valid select -> COUNT (run_cnt <= 1); invalid select -> IDLE.
- Commit for digit i (index of the low select bit):
  - legal glyph: digits[i] <= value, digit_valid[i] <= 1.
  - blank: digits[i] unchanged, digit_valid[i] <= 0, no err.
  - any other pattern: digits[i] and digit_valid[i] unchanged; err <= 1 for one cycle; err_digit <= i.
- Frame tracking: seen mask set bit i on every commit (legal, blank, or error). When the commit makes the mask all ones: frame_done pulses on the same edge as the digit update, and the mask clears on that edge.
- Recommitting the same digit before the frame completes updates its value; mask unaffected.

## Timing

- Reset (async assert, sync-safe release): digits = 0, digit_valid = 0, frame_done = 0, err = 0, err_digit = 0, FSM = IDLE, run_cnt = 0, seen mask = 0. Reset mid-run discards the partial count; no commit follows release until a new full stable run.
- Latency: pattern first present at edge E0 (seg_q loaded, run_cnt = 1). Pins held through E(STABLE_CYCLES-1) -> outputs update at E(STABLE_CYCLES). Default: visible after the 5th rising edge.
- Pattern held STABLE_CYCLES-1 edges or fewer: no commit, no err.
- frame_done and err are single-cycle pulses, both may assert on the same edge.
- Select with zero or multiple lows is never committed and never raises err.

## Test plan

- Reset, then seg_n=0110000, dig_sel_n=1110 held 4 edges -> at 5th edge digits[3:0]=3, digit_valid=0001, err=0, frame_done=0.
- Same pattern held 3 edges, then dig_sel_n=1111 -> no output change, err never asserts.
- Scan 1101:A, 1011:2, 0111:F after digit 0=1 (each held 6 edges) -> digits=F2A1 hex, digit_valid=1111, frame_done one pulse on the digit-3 commit edge, exactly one pulse.
- seg_n=0101010 on dig_sel_n=1011 held 4 edges -> err one-cycle pulse, err_digit=2, digits[11:8] and digit_valid[2] unchanged; then blank on digit 2 -> digit_valid[2]=0, no err.
- dig_sel_n=0011 with seg_n=0000000 held 20 edges -> no commit; assert rst_n low for 1 cycle during a 2-edge-old run of digit 1 -> all outputs 0, no commit after release until 4 new stable edges.
